// File: rtl/updown_cnt_ctrl.sv
// Purpose : up/down/ping-pong sweep sequencer wrapping a W-bit count register; optional feature macro UDC_PAUSE_EN.
// Latency : start edge shows the first bound on cnt_o; done_o pulses one edge after the final terminal value.
// Backpress: start_i is ignored while busy_o; abort_i ends a sweep early; pause_i freezes it when UDC_PAUSE_EN.
module updown_cnt_ctrl #(
  parameter int W  = 4,
  parameter int PW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [1:0]    mode_i,
  input  logic [W-1:0]  lo_i,
  input  logic [W-1:0]  hi_i,
  input  logic [PW-1:0] passes_i,
  input  logic          abort_i,
  input  logic          pause_i,
  output logic [W-1:0]  cnt_o,
  output logic          sel_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [PW-1:0] pass_cnt_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_PP   = 2'd2;
  localparam logic [1:0] MODE_BAD  = 2'd3;

  state_t        state;
  logic [1:0]    mode_q;
  logic [W-1:0]  lo_q;
  logic [W-1:0]  hi_q;
  logic [PW-1:0] passes_q;

  logic          cfg_bad;
  logic          flat;
  logic          at_term;
  logic [PW-1:0] pass_inc;
  logic          last_pass;
  logic          pause_act;

`ifdef UDC_PAUSE_EN
  assign pause_act = pause_i;
`else
  // Pause is compiled out; the port stays so the pinout is build-independent.
  logic unused_pause;
  assign unused_pause = pause_i;
  assign pause_act    = 1'b0;
`endif

  // A start request with an illegal mode, inverted bounds or zero passes is rejected.
  assign cfg_bad   = (mode_i == MODE_BAD) || (lo_i > hi_i) || (passes_i == '0);
  assign flat      = (lo_q == hi_q);
  assign pass_inc  = pass_cnt_o + PW'(1);
  assign last_pass = (pass_inc == passes_q);

  // Terminal detection: a degenerate range completes a pass every cycle, otherwise per mode.
  always_comb begin
    at_term = 1'b0;
    if (flat) begin
      at_term = 1'b1;
    end else begin
      case (mode_q)
        MODE_UP:   at_term = (cnt_o == hi_q);
        MODE_DOWN: at_term = (cnt_o == lo_q);
        default:   at_term = (cnt_o == lo_q) && !sel_o;
      endcase
    end
  end

  // Sequencer: start capture, stepping, pass accounting, abort/pause and the pulse outputs.
  always_ff @(posedge clk_i) begin
    done_o <= 1'b0;
    err_o  <= 1'b0;
    if (rst_i) begin
      state      <= IDLE;
      mode_q     <= MODE_UP;
      lo_q       <= '0;
      hi_q       <= '0;
      passes_q   <= '0;
      cnt_o      <= '0;
      sel_o      <= 1'b1;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      pass_cnt_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            if (cfg_bad) begin
              err_o <= 1'b1;
            end else begin
              mode_q     <= mode_i;
              lo_q       <= lo_i;
              hi_q       <= hi_i;
              passes_q   <= passes_i;
              pass_cnt_o <= '0;
              busy_o     <= 1'b1;
              state      <= RUN;
              if (mode_i == MODE_DOWN) begin
                cnt_o <= hi_i;
                sel_o <= 1'b0;
              end else begin
                cnt_o <= lo_i;
                sel_o <= 1'b1;
              end
            end
          end
        end

        RUN: begin
          if (abort_i) begin
            // Everything visible holds so the host can see where the sweep stopped.
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (!pause_act) begin
            if (at_term) begin
              pass_cnt_o <= pass_inc;
              if (last_pass) begin
                state  <= IDLE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
              end else if (!flat) begin
                case (mode_q)
                  MODE_DOWN: cnt_o <= hi_q;
                  MODE_PP: begin
                    // The terminal lo doubles as the start of the next pass.
                    cnt_o <= lo_q + W'(1);
                    sel_o <= 1'b1;
                  end
                  default:   cnt_o <= lo_q;
                endcase
              end
            end else if (sel_o && (cnt_o == hi_q)) begin
              // Only ping-pong reaches hi without terminating: turn around.
              cnt_o <= hi_q - W'(1);
              sel_o <= 1'b0;
            end else if (sel_o) begin
              cnt_o <= cnt_o + W'(1);
            end else begin
              cnt_o <= cnt_o - W'(1);
            end
          end
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updown_cnt_ctrl.sv
// Bench for updown_cnt_ctrl: expected per-edge outputs are queued at launch and popped after each edge.
// Sweep expectations are generated from per-pass value lists, not from a copy of the sequencer.
// Honours UDC_PAUSE_EN for the pause scenario.
module tb_updown_cnt_ctrl;

  localparam int W  = 4;
  localparam int PW = 8;

`ifdef UDC_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [1:0]    mode_i = '0;
  logic [W-1:0]  lo_i = '0;
  logic [W-1:0]  hi_i = '0;
  logic [PW-1:0] passes_i = '0;
  logic          abort_i = 1'b0;
  logic          pause_i = 1'b0;
  logic [W-1:0]  cnt_o;
  logic          sel_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [PW-1:0] pass_cnt_o;

  updown_cnt_ctrl #(.W(W), .PW(PW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .lo_i       (lo_i),
    .hi_i       (hi_i),
    .passes_i   (passes_i),
    .abort_i    (abort_i),
    .pause_i    (pause_i),
    .cnt_o      (cnt_o),
    .sel_o      (sel_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .pass_cnt_o (pass_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int cnt;
    int sel;
    int busy;
    int done;
    int err;
    int pc;
  } exp_t;

  exp_t seq[$];
  exp_t sb[$];
  exp_t last;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_out(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    chk({name, ".cnt"},  32'(cnt_o),      e.cnt);
    chk({name, ".sel"},  32'(sel_o),      e.sel);
    chk({name, ".busy"}, 32'(busy_o),     e.busy);
    chk({name, ".done"}, 32'(done_o),     e.done);
    chk({name, ".err"},  32'(err_o),      e.err);
    chk({name, ".pass"}, 32'(pass_cnt_o), e.pc);
  endtask

  task automatic tick(input string name);
    @(posedge clk_i);
    #1;
    compare_out(name);
  endtask

  task automatic push_exp(input int v, input int s, input int pc);
    exp_t e;
    e = '{cnt: v, sel: s, busy: 1, done: 0, err: 0, pc: pc};
    seq.push_back(e);
  endtask

  // cut_kind: 0 none, 1 abort, 2 reset, applied on the edge after record cut_at.
  task automatic run_sweep(input string name, input int mode, input int lo, input int hi,
                           input int passes, input int cut_at, input int cut_kind,
                           input int pause_at, input int pause_len, input bit hammer);
    exp_t e;
    int   n;
    seq.delete();
    for (int p = 0; p < passes; p++) begin
      if (lo == hi) begin
        push_exp(lo, (mode == 1) ? 0 : 1, p);
      end else if (mode == 0) begin
        for (int v = lo; v <= hi; v++) push_exp(v, 1, p);
      end else if (mode == 1) begin
        for (int v = hi; v >= lo; v--) push_exp(v, 0, p);
      end else begin
        for (int v = (p == 0) ? lo : lo + 1; v <= hi; v++) push_exp(v, 1, p);
        for (int v = hi - 1; v >= lo; v--) push_exp(v, 0, p);
      end
    end
    e = seq[seq.size() - 1];
    e.busy = 0;
    e.done = 1;
    e.pc   = passes;
    seq.push_back(e);
    e.done = 0;
    seq.push_back(e);

    if (cut_kind != 0) begin
      if (cut_kind == 1) begin
        e = seq[cut_at];
        e.busy = 0;
      end else begin
        e = '{cnt: 0, sel: 1, busy: 0, done: 0, err: 0, pc: 0};
      end
      while (seq.size() > cut_at + 1) void'(seq.pop_back());
      seq.push_back(e);
      seq.push_back(e);
    end

    if (pause_len > 0 && PAUSE_ON) begin
      for (int k = 0; k < pause_len; k++) seq.insert(pause_at + 1, seq[pause_at]);
    end

    n = seq.size();
    foreach (seq[i]) sb.push_back(seq[i]);

    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        start_i  = 1'b1;
        mode_i   = 2'(mode);
        lo_i     = W'(lo);
        hi_i     = W'(hi);
        passes_i = PW'(passes);
      end else if (hammer && i <= n - 2) begin
        // Illegal config while busy: must be neither captured nor flagged.
        start_i  = 1'b1;
        mode_i   = 2'd3;
        lo_i     = 4'd15;
        hi_i     = 4'd0;
        passes_i = '0;
      end else begin
        start_i = 1'b0;
      end
      abort_i = (cut_kind == 1) && (i == cut_at + 1);
      rst_i   = (cut_kind == 2) && (i == cut_at + 1);
      pause_i = (pause_len > 0) && (i > pause_at) && (i <= pause_at + pause_len);
      tick($sformatf("%s[E%0d]", name, i));
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    rst_i   = 1'b0;
    pause_i = 1'b0;
    last    = seq[n - 1];
  endtask

  task automatic err_case(input string name, input int mode, input int lo, input int hi,
                          input int passes);
    exp_t e;
    e = last;
    e.busy = 0;
    e.done = 0;
    e.err  = 1;
    sb.push_back(e);
    start_i  = 1'b1;
    mode_i   = 2'(mode);
    lo_i     = W'(lo);
    hi_i     = W'(hi);
    passes_i = PW'(passes);
    tick({name, "[pulse]"});
    start_i = 1'b0;
    e.err = 0;
    sb.push_back(e);
    tick({name, "[after]"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    r = '{cnt: 0, sel: 1, busy: 0, done: 0, err: 0, pc: 0};
    rst_i = 1'b1;
    @(posedge clk_i);
    sb.push_back(r);
    tick("reset");
    rst_i = 1'b0;
    last = r;

    run_sweep("up_2_5_x2",   0, 2, 5, 2, 0, 0, 0, 0, 1'b1);
    run_sweep("pp_1_3_x1",   2, 1, 3, 1, 0, 0, 0, 0, 1'b0);
    run_sweep("down_0_15",   1, 0, 15, 1, 0, 0, 0, 0, 1'b0);
    err_case("err_lo_gt_hi", 0, 6, 3, 1);
    err_case("err_passes0",  0, 1, 4, 0);
    err_case("err_mode3",    3, 1, 4, 1);
    run_sweep("abort_at_4",  0, 2, 5, 2, 2, 1, 0, 0, 1'b0);

    // abort while idle changes nothing
    sb.push_back(last);
    abort_i = 1'b1;
    tick("idle_abort");
    abort_i = 1'b0;

    run_sweep("rst_mid",     0, 2, 5, 2, 3, 2, 0, 0, 1'b0);
    run_sweep("flat_7_x3",   0, 7, 7, 3, 0, 0, 0, 0, 1'b0);
    run_sweep("pp_0_2_x2",   2, 0, 2, 2, 0, 0, 0, 0, 1'b0);
    run_sweep("down_3_6_x2", 1, 3, 6, 2, 0, 0, 0, 0, 1'b1);
    run_sweep("pause_up",    0, 2, 5, 2, 0, 0, 2, 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
